// File: rtl/cpu_types_pkg.sv
// Shared fetch-side types: word type, fetch FSM states, IF/ID latch record.
// Optional FETCH_PERF_EN build adds fetch/stall counters to fetch_stage.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instru;
    word_t pc;
    word_t npc;
    logic  deen;
  } ifid_t;

  localparam word_t PC_STEP = 32'd4;
  localparam ifid_t BUBBLE_IFID = '{instru: 32'h0000_0000, pc: 32'h0000_0000,
                                    npc: 32'h0000_0000, deen: 1'b0};

  // Build a valid IF/ID record for an instruction fetched at addr.
  function automatic ifid_t make_ifid(input word_t instr, input word_t addr);
    make_ifid = '{instru: instr, pc: addr, npc: addr + PC_STEP, deen: 1'b1};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic word_t sat_inc(input word_t v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking an instruction that returned while decode was stalled.
module fetch_hold_buf
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  drain,
  input  logic  clear,
  input  ifid_t load_data,
  output logic  valid,
  output ifid_t data
);

  logic  valid_r;
  ifid_t data_r;

  // Clear wins over load; drain only empties the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= BUBBLE_IFID;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (drain) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID latch and stall hold buffer.
// Define FETCH_PERF_EN to add the fetch_cnt/stall_cnt performance counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instru,
  output logic [31:0] PC,
  output logic [31:0] nPC,
`ifdef FETCH_PERF_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        deen
);

  fetch_state_t state_r, state_next_s;
  word_t        pc_r, pc_next_s;
  ifid_t        ifid_r, ifid_next_s, hold_data_s;
  logic         hold_valid_s, hold_load_s, hold_drain_s, hold_clear_s;
  logic         imem_ren_s, accept_s;

  fetch_hold_buf u_hold (
    .clk      (CLK),
    .rst_n    (nRST),
    .load     (hold_load_s),
    .drain    (hold_drain_s),
    .clear    (hold_clear_s),
    .load_data(make_ifid(iload, pc_r)),
    .valid    (hold_valid_s),
    .data     (hold_data_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_r <= FETCH;
    else       state_r <= state_next_s;
  end

  // FSM next state: HALTED is left only through reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH:   state_next_s = halt ? HALTED : FETCH;
      HALTED:  state_next_s = HALTED;
      default: state_next_s = FETCH;
    endcase
  end

  // FSM output: no request while halting or while the hold entry is occupied.
  always_comb begin
    imem_ren_s = 1'b0;
    case (state_r)
      FETCH:   imem_ren_s = !hold_valid_s && !halt;
      default: imem_ren_s = 1'b0;
    endcase
  end

  assign accept_s = ihit && imem_ren_s && !redirect;

  // PC / IF/ID / hold control in priority order redirect > flush > stall > normal.
  always_comb begin
    pc_next_s    = pc_r;
    ifid_next_s  = ifid_r;
    hold_load_s  = 1'b0;
    hold_drain_s = 1'b0;
    hold_clear_s = 1'b0;
    if (state_r == HALTED) begin
      ifid_next_s  = BUBBLE_IFID;
      hold_clear_s = 1'b1;
    end else if (redirect) begin
      pc_next_s    = redirect_pc;
      ifid_next_s  = BUBBLE_IFID;
      hold_clear_s = 1'b1;
    end else if (flush) begin
      ifid_next_s  = BUBBLE_IFID;
      hold_clear_s = 1'b1;
      pc_next_s    = accept_s ? pc_r + PC_STEP : pc_r;
    end else if (stall) begin
      if (accept_s) begin
        hold_load_s = 1'b1;
        pc_next_s   = pc_r + PC_STEP;
      end else begin
        pc_next_s   = pc_r;
      end
    end else if (hold_valid_s) begin
      ifid_next_s  = hold_data_s;
      hold_drain_s = 1'b1;
    end else if (accept_s) begin
      ifid_next_s = make_ifid(iload, pc_r);
      pc_next_s   = pc_r + PC_STEP;
    end else begin
      ifid_next_s = BUBBLE_IFID;
    end
  end

  // PC and IF/ID latch registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_r   <= PC_INIT;
      ifid_r <= BUBBLE_IFID;
    end else begin
      pc_r   <= pc_next_s;
      ifid_r <= ifid_next_s;
    end
  end

  assign imemREN  = imem_ren_s;
  assign imemaddr = pc_r;
  assign instru   = ifid_r.instru;
  assign PC       = ifid_r.pc;
  assign nPC      = ifid_r.npc;
  assign deen     = ifid_r.deen;

`ifdef FETCH_PERF_EN
  word_t fetch_cnt_r, stall_cnt_r;

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt_r <= 32'h0000_0000;
      stall_cnt_r <= 32'h0000_0000;
    end else begin
      if (accept_s) fetch_cnt_r <= sat_inc(fetch_cnt_r);
      if ((state_r == FETCH) && stall) stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign fetch_cnt = fetch_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage plus IF/ID pipeline latch, directly upstream of the decode stage. Owns the PC and issues instruction-memory reads. A one-entry hold buffer keeps an instruction that returns while decode is stalled. Presents instru/PC/nPC/deen to decode and accepts redirects (decode PCSrc), flush and halt back from decode.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded at reset

Ports:
CLK  input  1  system clock
nRST  input  1  asynchronous active-low reset
ihit  input  1  imem read complete this cycle; iload valid
iload  input  32  instruction word from imem
imemREN  output  1  imem read request
imemaddr  output  32  imem read address, equals current PC
stall  input  1  hazard unit: hold IF/ID contents
flush  input  1  squash IF/ID contents
redirect  input  1  load PC from redirect_pc (taken branch/jump from decode)
redirect_pc  input  32  target PC (word_t)
halt  input  1  halt seen by decode
instru  output  32  IF/ID instruction to decode
PC  output  32  IF/ID address of instru
nPC  output  32  IF/ID PC+4 of instru
deen  output  1  IF/ID valid; decode enable

Behaviour:
- Reset (async, nRST=0): pc_q=PC_INIT; instru=0, PC=0, nPC=0, deen=0; hold empty; state=FETCH. Reset mid-fetch discards everything.
- States: FETCH, HALTED. FETCH->HALTED when halt=1 (at clock edge). HALTED exits only by reset.
- imemREN = (state==FETCH) && !hold_valid && !halt. imemaddr = pc_q, combinational.
- accept = ihit && imemREN && !redirect.
- Priority per edge: redirect > flush > stall > normal.
- redirect=1: pc_q<=redirect_pc; hold cleared; IF/ID<=bubble (instru=0, deen=0); same-cycle ihit data dropped. Applies even when stall=1.
- flush=1 (no redirect): IF/ID<=bubble; hold cleared; an accepted fetch still advances pc_q<=pc_q+4 and its instruction is dropped.
- stall=1: IF/ID unchanged. On accept: hold<= {iload, pc_q}, hold_valid<=1, pc_q<=pc_q+4. Hold already full: imemREN=0, nothing advances.
- Normal (no stall): hold_valid -> IF/ID<=hold, hold_valid<=0 (imemREN was 0). Else on accept -> instru<=iload, PC<=pc_q, nPC<=pc_q+4, deen<=1, pc_q<=pc_q+4. Else IF/ID<=bubble.
- Fetch latency: one edge from ihit to deen=1 when unstalled.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0, no flag.
- HALTED: imemREN=0, pc_q frozen, IF/ID<=bubble every edge. halt together with accept: the instruction is dropped.
- redirect_pc alignment is not checked; low bits pass through.

Optional Feature:
FETCH_PERF_EN: adds outputs fetch_cnt[31:0] (accepted fetches) and stall_cnt[31:0] (cycles with state==FETCH and stall=1). Both reset to 0 and saturate at 32'hFFFF_FFFF. When the macro is undefined, the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- cpu_types_pkg: word_t; new typedef fetch_state_t {FETCH, HALTED}; typedef ifid_t struct {instru, PC, nPC, deen}; constant BUBBLE_IFID.
- Hold buffer and IF/ID use ifid_t.
- Natural sub-module: fetch_hold_buf (one-entry buffer with load/drain/clear).
- Top-level port bundle: new interface fetch_if with modport fe, alongside decode_if.

Test Plan:
- Reset, PC_INIT=0, ihit=1 every cycle, iload=addr-tagged -> imemaddr 0,4,8; deen=1 from first edge after reset; nPC=PC+4.
- ihit at pc=8 while stall=1 -> hold keeps word@8, imemREN=0, imemaddr=12 stays. After stall drops -> instru=word@8, PC=8, then fetch of 12 resumes.
- redirect=1, redirect_pc=32'h0000_0040 with stall=1 and ihit=1 -> next cycle imemaddr=0x40, deen=0, hold empty.
- flush=1 with accept at pc=0x10 -> deen=0, next imemaddr=0x14.
- halt=1 -> imemREN=0 forever, deen=0, imemaddr frozen until nRST=0.
- pc_q=32'hFFFF_FFFC, ihit -> next imemaddr=0, nPC output=0. With FETCH_PERF_EN: 5 accepts + 3 stall cycles -> fetch_cnt=5, stall_cnt=3.
